// File: rtl/reset_phase_gen.sv
// Purpose  : stretches an incoming synchronous reset, then sequences a one-hot
//            machine-phase cycle continuously (run) or once per request (step).
// Latency  : phase[0] appears 1 clock after a sampled run/step in IDLE. reset_out
//            drops on the RESET_HOLD-th edge that samples reset low.
// Backpr.  : none. Cycles always run to completion. step is ignored while busy or
//            in HOLD and is not queued.
// Ports    : clock, reset (sync, active-high), run (level), step (sampled request)
//            -> reset_out, phase (one-hot), phase_idx, cycle_start, cycle_count, busy
module reset_phase_gen #(
   parameter int RESET_HOLD = 4,
   parameter int NPHASE     = 4,
   parameter int CNT_WIDTH  = 16,
   localparam int IW = (NPHASE > 1) ? $clog2(NPHASE) : 1,
   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 step,
   output logic                 reset_out,
   output logic [NPHASE-1:0]    phase,
   output logic [IW-1:0]        phase_idx,
   output logic                 cycle_start,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic last_phase;
   assign last_phase = (idx_q == IW'(NPHASE - 1));

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_HOLD: begin
            // Count edges with reset low. The final one leaves HOLD directly,
            // so reset_out drops on exactly the RESET_HOLD-th edge.
            if (hold_cnt_q == HW'(RESET_HOLD - 1)) begin
               state_d    = ST_IDLE;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
            idx_d = '0;
         end
         ST_IDLE: begin
            idx_d = '0;
            if (run) begin
               state_d = ST_RUN;
            end else if (step) begin
               state_d = ST_STEP;
            end
         end
         default: begin // ST_RUN, ST_STEP
            if (last_phase) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               idx_d = '0;
               // Going back-to-back into RUN avoids a gap cycle. A STEP that
               // ends with run high also continues as RUN.
               state_d = run ? ST_RUN : ST_IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      phase = '0;
      if (busy) begin
         phase[idx_q] = 1'b1;
      end
   end

   assign busy        = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign reset_out   = (state_q == ST_HOLD);
   assign phase_idx   = busy ? idx_q : '0;
   assign cycle_start = phase[0];
   assign cycle_count = cnt_q;

endmodule

// File: doc/reset_phase_gen.md
RESET_PHASE_GEN -- requirements
Module: reset_phase_gen

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 4, number of clock edges reset_out stays high after reset is released (legal: >= 1).
REQ-002 SHALL have parameter NPHASE, default 4, number of machine phases per cycle (legal: >= 2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the completed-cycle counter.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port run  input  1  level; run phases continuously while high.
REQ-007 SHALL have port step  input  1  sampled each edge; requests exactly one full phase cycle.
REQ-008 SHALL have port reset_out  output  1  stretched reset for the downstream machine.
REQ-009 SHALL have port phase  output  NPHASE  one-hot phase enable, all-zero when not cycling.
REQ-010 SHALL have port phase_idx  output  max(1,$clog2(NPHASE))  index of the active phase.
REQ-011 SHALL have port cycle_start  output  1  high when phase[0] is high.
REQ-012 SHALL have port cycle_count  output  CNT_WIDTH  number of completed phase cycles.
REQ-013 SHALL have port busy  output  1  high in RUN or STEP.

Function
REQ-014 SHALL implement states HOLD, IDLE, RUN and STEP, all registered.
REQ-015 SHALL, in HOLD, count edges with reset low; after RESET_HOLD such edges, go to IDLE and drop reset_out on that same edge.
REQ-016 SHALL keep phase all-zero, phase_idx 0, cycle_start 0 and busy 0 in HOLD and IDLE.
REQ-017 SHALL, from IDLE, go to RUN when run=1, else to STEP when step=1; run has priority when both are high.
REQ-018 SHALL assert phase[0] on the same edge that enters RUN or STEP (latency 1 clock from sampled request).
REQ-019 SHALL, in RUN/STEP, advance phase one-hot by one position per clock, phase_idx 0..NPHASE-1.
REQ-020 SHALL increment cycle_count modulo 2^CNT_WIDTH on each edge leaving phase NPHASE-1; all-ones wraps to 0.
REQ-021 SHALL never abort a cycle: when run falls mid-cycle, finish through phase NPHASE-1 before stopping.
REQ-022 SHALL, at the end of a cycle (edge leaving NPHASE-1): go to RUN with phase[0] if run=1, with no gap cycle; otherwise go to IDLE with phase all-zero.
REQ-023 SHALL make STEP complete exactly one cycle; if run=1 at its end, continue per REQ-022.
REQ-024 SHALL ignore step while busy or in HOLD; step is not queued.
REQ-025 SHALL treat step held high in IDLE as a new request each time IDLE is re-entered (one cycle, one idle clock, repeat).

Reset
REQ-026 SHALL, on any edge sampling reset=1 in any state, go to HOLD and clear the hold counter; set reset_out=1, phase=0, phase_idx=0 and cycle_count=0; this includes resets mid-cycle.
REQ-027 SHALL restart the hold count if reset is reasserted during HOLD.
REQ-028 SHALL not act on run or step until HOLD has exited.
REQ-029 SHALL reach the same post-reset state from power-up once reset has been asserted for at least one edge; no initial blocks are required.

Verification
REQ-030 Reset high 3 clocks then low -> reset_out high for exactly 4 further edges, then 0; state IDLE; cycle_count=0.
REQ-031 run=1 held after reset_out falls -> phase 0001,0010,0100,1000,0001... on consecutive clocks; cycle_count=1 after 4 phases, 3 after 12.
REQ-032 In IDLE, step pulsed 1 clock -> phases 0001..1000 once, then 0000; busy high exactly 4 clocks; cycle_count +1. A second step pulse during phase 0100 -> no extra cycle.
REQ-033 In RUN, run dropped during phase 0010 -> 0100 and 1000 still appear, then 0000; cycle_count +1.
REQ-034 In RUN, reset pulsed during phase 0100 -> next edge phase=0000, reset_out=1, cycle_count=0; RESET_HOLD hold then IDLE.
REQ-035 CNT_WIDTH=4, run held 16 cycles -> cycle_count wraps 15 to 0 with no glitch in phase.
